// File: rtl/vga_clkgen_prog.sv
// DCM_CLKGEN programming-port driver: shifts LoadD, LoadM and GO onto PROGCLK/PROGEN/PROGDATA,
// then waits for PROGDONE and LOCKED. Define VGA_CLKGEN_TIMEOUT_EN to bound the final wait.
module vga_clkgen_prog #(
  parameter int unsigned PROG_DIV    = 2,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] m,
  input  logic [7:0] d,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       progclk,
  output logic       progen,
  output logic       progdata,
  input  logic       progdone,
  input  logic       locked
);

  localparam int unsigned DivW = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;

  if (PROG_DIV < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << 21)) begin : g_param_check
    $error("vga_clkgen_prog: PROG_DIV or TIMEOUT_CYC out of range");
  end

  typedef enum logic [2:0] {
    StIdle, StLoadD, StGap1, StLoadM, StGap2, StGo, StWaitDone, StWaitLock
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic            progclk_q;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      per_q, per_d;
  logic [9:0]      sh_q, sh_d;
  logic [7:0]      m_q, m_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic            progen_q, progen_d, progdata_q, progdata_d;
  logic            pd_meta, pd_sync, lk_meta, lk_sync;
  logic            div_tc, fall_tick, tmo_hit;

  assign div_tc    = (div_q == DivW'(PROG_DIV - 1));
  assign fall_tick = div_tc & progclk_q;

`ifdef VGA_CLKGEN_TIMEOUT_EN
  localparam logic [20:0] TmoLast = 21'(TIMEOUT_CYC - 1);
  logic [20:0] tmo_q;

  // Held at zero through GO so counting begins on the cycle WAIT_DONE is entered.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_q <= '0;
    end else if (state_q == StGo) begin
      tmo_q <= '0;
    end else if (state_q == StWaitDone || state_q == StWaitLock) begin
      tmo_q <= tmo_q + 21'd1;
    end
  end

  assign tmo_hit = (state_q == StWaitDone || state_q == StWaitLock) && (tmo_q == TmoLast);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      progclk_q  <= 1'b0;
      bit_q      <= '0;
      per_q      <= '0;
      sh_q       <= '0;
      m_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
      pd_meta    <= 1'b0;
      pd_sync    <= 1'b0;
      lk_meta    <= 1'b0;
      lk_sync    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_tc ? '0 : div_q + DivW'(1);
      progclk_q  <= div_tc ? ~progclk_q : progclk_q;
      bit_q      <= bit_d;
      per_q      <= per_d;
      sh_q       <= sh_d;
      m_q        <= m_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      progen_q   <= progen_d;
      progdata_q <= progdata_d;
      pd_meta    <= progdone;
      pd_sync    <= pd_meta;
      lk_meta    <= locked;
      lk_sync    <= lk_meta;
    end
  end

  // state_q names the slot kind that the next falling tick will drive.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    per_d      = per_q;
    sh_d       = sh_q;
    m_d        = m_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    progen_d   = progen_q;
    progdata_d = progdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = m;
          error_d = (m == 8'd0);
          if (m == 8'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            sh_d    = {d, 2'b01};
            bit_d   = '0;
            state_d = StLoadD;
          end
        end
      end
      StLoadD, StLoadM: begin
        if (fall_tick) begin
          progen_d   = 1'b1;
          progdata_d = sh_q[0];
          sh_d       = {1'b0, sh_q[9:1]};
          if (bit_q == 4'd9) begin
            bit_d   = '0;
            per_d   = '0;
            state_d = (state_q == StLoadD) ? StGap1 : StGap2;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StGap1, StGap2: begin
        if (fall_tick) begin
          progen_d   = 1'b0;
          progdata_d = 1'b0;
          if (per_q == 2'd1) begin
            per_d = '0;
            bit_d = '0;
            if (state_q == StGap1) begin
              sh_d    = {m_q, 2'b11};
              state_d = StLoadM;
            end else begin
              state_d = StGo;
            end
          end else begin
            per_d = per_q + 2'd1;
          end
        end
      end
      StGo: begin
        if (fall_tick) begin
          progdata_d = 1'b0;
          if (per_q == 2'd0) begin
            progen_d = 1'b1;
            per_d    = 2'd1;
          end else begin
            progen_d = 1'b0;
            per_d    = '0;
            state_d  = StWaitDone;
          end
        end
      end
      StWaitDone, StWaitLock: begin
        if (tmo_hit) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (state_q == StWaitDone) begin
          if (pd_sync) state_d = StWaitLock;
        end else if (lk_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign progclk  = progclk_q;
  assign progen   = progen_q;
  assign progdata = progdata_q;

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Directed bench for vga_clkgen_prog (PROG_DIV=2, TIMEOUT_CYC=64); outputs sampled on negedge.
module tb_vga_clkgen_prog;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] m = 8'd0;
  logic [7:0] d = 8'd0;
  logic       busy, done, error, progclk, progen, progdata;
  logic       progdone = 1'b0;
  logic       locked = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  vga_clkgen_prog #(
    .PROG_DIV    (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .m        (m),
    .d        (d),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .progclk  (progclk),
    .progen   (progen),
    .progdata (progdata),
    .progdone (progdone),
    .locked   (locked)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {progen, progdata} for PROGCLK period i of a full sequence.
  function automatic logic [1:0] exp_slot(input int i, input logic [7:0] mv, input logic [7:0] dv);
    logic [9:0] dbits;
    logic [9:0] mbits;
    dbits = {dv, 2'b01};
    mbits = {mv, 2'b11};
    if (i < 10)      return {1'b1, dbits[i]};
    else if (i < 12) return 2'b00;
    else if (i < 22) return {1'b1, mbits[i-12]};
    else if (i < 24) return 2'b00;
    else             return 2'b10;
  endfunction

  task automatic pulse_start(input logic [7:0] mv, input logic [7:0] dv);
    m = mv;
    d = dv;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input logic [7:0] mv, input logic [7:0] dv, input bit inject);
    bit seen;
    logic [1:0] e;
    pulse_start(mv, dv);
    check_eq("start_busy", busy, 1);
    check_eq("start_err_clr", error, 0);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge sys_clk);
      if (progen) seen = 1;
    end
    check_eq("first_tick", seen, 1);
    if (!seen) return;
    for (int i = 0; i < 25; i++) begin
      e = exp_slot(i, mv, dv);
      check_eq($sformatf("slot%0d_head", i), {progen, progdata}, e);
      if (i == 0) check_eq("progclk_low", progclk, 0);
      if (inject && i == 14) begin
        start = 1'b1;
        m = 8'hAA;
        d = 8'h55;
      end
      @(negedge sys_clk);
      start = 1'b0;
      if (inject && i == 14) check_eq("inject_busy", busy, 1);
      repeat (2) @(negedge sys_clk);
      check_eq($sformatf("slot%0d_tail", i), {progen, progdata}, e);
      if (i == 0) check_eq("progclk_high", progclk, 1);
      @(negedge sys_clk);
    end
    check_eq("go_end_progen", progen, 0);
    check_eq("go_end_busy", busy, 1);
  endtask

  task automatic finish_seq(input int hold);
    int ndone;
    int k;
    progdone = 1'b1;
    ndone = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    if (hold > 0) begin
      check_eq("hold_busy", busy, 1);
      check_eq("hold_no_done", ndone, 0);
      locked = 1'b1;
    end
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(negedge sys_clk);
      if (done) k = c;
    end
    check_eq("done_latency_3_4", (k >= 3 && k <= 4), 1);
    check_eq("done_error", error, 0);
    check_eq("done_busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    check_eq("single_done", ndone, 0);
    progdone = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rises;
    int ndone;
    logic prev;
    #2;
    check_eq("rst_outs", {busy, done, error, progclk, progen, progdata}, 6'b0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // progclk free-runs in IDLE: period 4 sys_clk
    rises = 0;
    prev = progclk;
    for (int c = 0; c < 16; c++) begin
      @(negedge sys_clk);
      if (!prev && progclk) rises++;
      prev = progclk;
    end
    check_eq("idle_progclk_rises", rises, 4);

    // Normal sequence m=3 d=1
    run_seq(8'h03, 8'h01, 0);
    finish_seq(0);

    // m==0 rejected
    pulse_start(8'h00, 8'h05);
    check_eq("m0_done", done, 1);
    check_eq("m0_error", error, 1);
    check_eq("m0_busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (progen || busy || done) ndone++;
    end
    check_eq("m0_quiet", ndone, 0);
    check_eq("m0_err_sticky", error, 1);

    // Second start during LOAD_M is ignored
    run_seq(8'h5C, 8'hA3, 1);
    finish_seq(0);

    // Reset during LOAD_D bit 5
    pulse_start(8'h07, 8'hF0);
    for (int t = 0; t < 20 && !progen; t++) @(negedge sys_clk);
    repeat (21) @(negedge sys_clk);
    check_eq("pre_rst_progen", progen, 1);
    sys_rst = 1'b1;
    #1;
    check_eq("rst_mid_outs", {progen, progclk, busy}, 3'b000);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    run_seq(8'h81, 8'h3C, 0);
    finish_seq(0);

`ifdef VGA_CLKGEN_TIMEOUT_EN
    // progdone never rises: timeout 64 cycles after GO
    run_seq(8'h10, 8'h02, 0);
    ndone = 0;
    for (int c = 1; c <= 200 && ndone == 0; c++) begin
      @(negedge sys_clk);
      if (done) ndone = c;
    end
    check_eq("tmo_latency", ndone, 64);
    check_eq("tmo_error", error, 1);
    check_eq("tmo_busy", busy, 0);
    run_seq(8'h04, 8'h00, 0);
    finish_seq(0);
`else
    // locked low for 500 cycles after progdone
    locked = 1'b0;
    run_seq(8'hFF, 8'hFF, 0);
    finish_seq(500);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
